// File: rtl/soc_pio_pkg.sv
// Shared constants for the soc_pio_ext PIO slave: register offsets, edge modes
// and the edge-detect helper.
package soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUT      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_OUTTGL   = 3'd6;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Operates on full 32-bit words; callers keep only their WIDTH LSBs.
  function automatic logic [31:0] edge_detect(input int etype,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    case (etype)
      EDGE_FALL: return ~cur & prev;
      EDGE_ANY:  return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/soc_pio_sync.sv
// Multi-flop synchroniser for asynchronous PIO inputs; q is the last stage.
module soc_pio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/soc_pio_ext.sv
// Avalon-MM PIO slave: output register with set/clear/toggle aliases,
// synchronised input port with edge capture and a maskable level irq.
module soc_pio_ext
  import soc_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] out_reg, irq_mask, edge_cap;
  logic [WIDTH-1:0] in_sync, in_prev;
  logic [WIDTH-1:0] wdata, w1c, edge_hit;
  logic [31:0]      edge32;
  logic [2:0]       warm_cnt;
  logic             wr, warm;
  logic             unused_bits;

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign w1c   = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;
  assign warm  = (warm_cnt == WARM_MAX);

  soc_pio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (in_sync)
  );

  assign edge32   = edge_detect(EDGE_TYPE, 32'(in_sync), 32'(in_prev));
  assign edge_hit = edge32[WIDTH-1:0];

  // Bits above WIDTH are deliberately dropped.
  assign unused_bits = ^{writedata, edge32};

  always_ff @(posedge clk) begin
    if (reset) begin
      in_prev  <= '0;
      warm_cnt <= '0;
    end else begin
      in_prev <= in_sync;
      if (!warm) warm_cnt <= warm_cnt + 3'd1;
    end
  end

  // Capture is gated until the chain has flushed, so inputs held high
  // through reset do not look like fresh edges. A new edge beats a W1C.
  always_ff @(posedge clk) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~w1c) | (warm ? edge_hit : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg  <= RESET_VALUE[WIDTH-1:0];
      irq_mask <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA,
        ADDR_OUT:      out_reg  <= wdata;
        ADDR_IRQ_MASK: irq_mask <= wdata;
        ADDR_OUTSET:   out_reg  <= out_reg | wdata;
        ADDR_OUTCLR:   out_reg  <= out_reg & ~wdata;
        ADDR_OUTTGL:   out_reg  <= out_reg ^ wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:     readdata = 32'(in_sync);
        ADDR_OUT:      readdata = 32'(out_reg);
        ADDR_IRQ_MASK: readdata = 32'(irq_mask);
        ADDR_EDGE_CAP: readdata = 32'(edge_cap);
        default:       readdata = '0;
      endcase
    end
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: doc/soc_pio_ext.md
Name: soc_pio_ext

Overview:
- Parametrised Avalon-MM PIO slave; successor of the single-bit clock-select output port.
- Provides a WIDTH-bit output register with atomic set/clear/toggle aliases.
- Provides a synchronised WIDTH-bit input port with edge capture and a maskable level interrupt.
- Sits on the SoC debug bus alongside other Avalon slaves; out_port drives board or SoC control signals, in_port samples asynchronous sources.

Parameters:
- WIDTH, 8, port width in bits; legal 1..32.
- RESET_VALUE, 0, out_port value after reset; only WIDTH LSBs used.
- EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2, flops in the in_port synchroniser; legal 2..4.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits >= WIDTH ignored.
- readdata  out  32  read data; bits >= WIDTH read 0.
- in_port  in  WIDTH  asynchronous inputs.
- out_port  out  WIDTH  registered outputs.
- irq  out  1  level interrupt.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Write: occurs on the rising clk edge when chipselect=1 and write_n=0.
- Read: latency 0; readdata is a combinational mux of registered state, driven whenever selected, otherwise 0.
- Reset values: out_reg=RESET_VALUE, irq_mask=0, edge_cap=0, sync chain=0, in_prev=0, warm-up counter=0, irq=0.
- Register map:
  - 0 DATA: read = in_sync; write loads out_reg.
  - 1 OUT: read/write out_reg.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read; write-1-to-clear.
  - 4 OUTSET: write sets out_reg bits where writedata=1; reads 0.
  - 5 OUTCLR: write clears out_reg bits where writedata=1; reads 0.
  - 6 OUTTGL: write XORs writedata into out_reg; reads 0.
  - 7 reserved: reads 0; writes have no effect.
- out_port = out_reg; changes the clk edge after the write.
- Synchroniser: in_port passes through SYNC_STAGES flops; the last stage is in_sync. in_prev is in_sync delayed by one cycle.
- Edge detection:
  - rising: edge = in_sync & ~in_prev.
  - falling: edge = ~in_sync & in_prev.
  - any: edge = in_sync ^ in_prev.
- Capture: edge_cap <= (edge_cap & ~w1c) | edge.
  - A new edge and a W1C on the same bit in the same cycle leave the bit set; the new edge wins.
- Latency: an in_port transition stable before clk edge k sets edge_cap after edge k+SYNC_STAGES.
- irq = |(edge_cap & irq_mask), combinational from registers; asserts in the same cycle edge_cap or irq_mask makes the term true.
- Warm-up counter: after reset deassertion, counts SYNC_STAGES+1 cycles; edge capture is suppressed until it saturates. This prevents spurious captures from inputs held high through reset.
  - Counter saturates and holds.
  - Reasserting reset restarts warm-up.
- Reset mid-operation: all state returns to reset values on the next edge, including pending edges and the mask.
- Undefined writedata bits above WIDTH are ignored, never stored.

Decomposition:
- Package soc_pio_pkg:
  - address constants ADDR_DATA..ADDR_OUTTGL.
  - EDGE_RISE / EDGE_FALL / EDGE_ANY constants.
- Sub-module soc_pio_sync: WIDTH-bit, SYNC_STAGES-deep synchroniser chain with synchronous active-high reset.
- Edge logic, warm-up counter and register file live in the top module.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, reads of addresses 2 and 3 return 0.
- Write OUT=8'h0F, OUTSET=8'hF0, OUTCLR=8'h03, OUTTGL=8'h81 -> out_port reads 8'hFF, then 8'hFC, then 8'h7D; each value appears the cycle after its write.
- EDGE_TYPE=0, mask=8'h04, raise in_port[2] -> edge_cap=8'h04 and irq=1 exactly SYNC_STAGES+1 edges later; raising in_port[3] sets edge_cap bit 3 with irq unchanged.
- Write EDGE_CAP=8'h04 in the same cycle a new rising edge on bit 2 reaches the detector -> bit 2 stays 1, irq stays 1; a later W1C with no edge -> bit 2 clears, irq=0.
- in_port=8'hFF held through reset, EDGE_TYPE=0 -> edge_cap remains 0 after warm-up; a subsequent 0->1 on bit 0 is captured.
- EDGE_TYPE=2, toggle in_port[1] twice with the pulses spaced more than SYNC_STAGES cycles apart -> bit 1 captured on each transition; read of address 7 -> 0.
